matrix_engine: RTL and testbench

- Parametrised matrix coprocessor core.
- Fetches a square-matrix job from single-port RAM: dimension word, then matrix A, then matrix B.
- Executes one of four element-wise/structural operations and writes the N×N result back to the same RAM.
- Sits between the control interface (start/op/base) and the on-chip RAM.
- Replaces the fixed 5×5, 8-bit, add-only, free-running datapath with a handshaked, restartable engine.

---
 rtl/matrix_engine_if.sv | 27 ++
 rtl/matrix_engine.sv | 196 +++++++++++++++++++
 tb/tb_matrix_engine.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_engine_if.sv
// Control and RAM signal bundle for matrix_engine.
// The engine connects through the slave modport; controller/RAM model uses master.
interface matrix_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] base;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output start, op, base, mem_rdata,
    input  busy, done, error, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  start, op, base, mem_rdata,
    output busy, done, error, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/matrix_engine.sv
// Square-matrix coprocessor: reads N, A, B from RAM at base, writes N*N result after them.
// Define MATRIX_ENGINE_SAT_EN for saturating add/sub/mul instead of wrap-around.
module matrix_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5,
  parameter int unsigned ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  matrix_engine_if.slave bus_io
);
  localparam int unsigned Depth = MAX_N * MAX_N;
  localparam int unsigned NW    = $clog2(MAX_N + 1);
  localparam int unsigned NnW   = $clog2(Depth + 1);
  localparam int unsigned CntW  = NnW + 1;
  localparam logic [DATA_W-1:0] MaxNWord = DATA_W'(MAX_N);

  typedef enum logic [2:0] {StIdle, StRdSize, StLoad, StExec, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     r_q, r_d;
  logic [NW-1:0]     c_q, c_d;
  logic [NnW-1:0]    nn_q, nn_d;
  logic [NnW-1:0]    k_q, k_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_q [Depth];
  logic [DATA_W-1:0] a_d [Depth];
  logic [DATA_W-1:0] b_q [Depth];
  logic [DATA_W-1:0] b_d [Depth];

  logic [NW-1:0]     n_in;
  logic              size_bad;
  logic              can_start;
  logic [NnW-1:0]    t_idx;
  logic [DATA_W-1:0] a_el, b_el, a_tr, res;
`ifdef MATRIX_ENGINE_SAT_EN
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
`endif

  // Next-state logic; DONE/ERR also accept a start so jobs can run back-to-back.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    addr_d   = addr_q;
    n_d      = n_q;
    nn_d     = nn_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    n_in     = bus_io.mem_rdata[NW-1:0];
    size_bad = (bus_io.mem_rdata == '0) || (bus_io.mem_rdata > MaxNWord);
    can_start = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);

    unique case (state_q)
      StIdle, StDone, StErr: begin
        state_d = StIdle;
        if (bus_io.start) begin
          state_d = StRdSize;
          op_d    = bus_io.op;
          base_d  = bus_io.base;
          addr_d  = bus_io.base;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StRdSize: begin
        if (cnt_q == '0) begin
          // Issue the first A read while the size word is still in flight.
          addr_d = base_q + ADDR_W'(1);
          cnt_d  = CntW'(1);
        end else if (size_bad) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          state_d = StLoad;
          n_d     = n_in;
          nn_d    = NnW'(NnW'(n_in) * NnW'(n_in));
          addr_d  = base_q + ADDR_W'(2);
          cnt_d   = '0;
        end
      end
      StLoad: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q < {1'b0, nn_q}) begin
          a_d[NnW'(cnt_q)] = bus_io.mem_rdata;
        end else begin
          b_d[NnW'(cnt_q - {1'b0, nn_q})] = bus_io.mem_rdata;
        end
        if (cnt_q == {nn_q, 1'b0} - CntW'(1)) begin
          state_d = StExec;
          k_d     = '0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      StExec: begin
        k_d = k_q + NnW'(1);
        if (c_q == n_q - NW'(1)) begin
          c_d = '0;
          r_d = r_q + NW'(1);
        end else begin
          c_d = c_q + NW'(1);
        end
        if (k_q == nn_q - NnW'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Element datapath for result index k = r*N + c.
  always_comb begin
    t_idx = NnW'(c_q) * NnW'(n_q) + NnW'(r_q);
    a_el  = a_q[k_q];
    b_el  = b_q[k_q];
    a_tr  = a_q[t_idx];
`ifdef MATRIX_ENGINE_SAT_EN
    sum  = {1'b0, a_el} + {1'b0, b_el};
    prod = {{DATA_W{1'b0}}, a_el} * {{DATA_W{1'b0}}, b_el};
    case (op_q)
      2'b00:   res = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      2'b01:   res = (a_el < b_el) ? '0 : a_el - b_el;
      2'b10:   res = (|prod[2*DATA_W-1:DATA_W]) ? '1 : prod[DATA_W-1:0];
      default: res = a_tr;
    endcase
`else
    case (op_q)
      2'b00:   res = a_el + b_el;
      2'b01:   res = a_el - b_el;
      2'b10:   res = a_el * b_el;
      default: res = a_tr;
    endcase
`endif
  end

  // Write-side outputs decode straight from state so reset drops mem_we at once.
  assign bus_io.mem_we    = (state_q == StExec);
  assign bus_io.mem_addr  = (state_q == StExec) ?
                            base_q + ADDR_W'(1) + ADDR_W'({nn_q, 1'b0}) + ADDR_W'(k_q) :
                            addr_q;
  assign bus_io.mem_wdata = (state_q == StExec) ? res : '0;
  assign bus_io.busy      = (state_q == StRdSize) || (state_q == StLoad) ||
                            (state_q == StExec);
  assign bus_io.done      = (state_q == StDone) || (state_q == StErr);
  assign bus_io.error     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      nn_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      nn_q    <= nn_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Operand buffers need no reset; they are always filled before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  logic unused_can_start;
  assign unused_can_start = can_start;
endmodule

// File: tb/tb_matrix_engine.sv
// Scoreboard bench for matrix_engine: directed test-plan jobs plus randomized jobs.
// Honours MATRIX_ENGINE_SAT_EN in its reference model.
module tb_matrix_engine;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 8;
  localparam int unsigned MAXN = 5;
  localparam int          Top  = (1 << DW) - 1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int at; logic err; } dn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  matrix_engine #(.DATA_W(DW), .MAX_N(MAXN), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic [DW-1:0] ram  [256];
  logic [DW-1:0] seen [256];
  int  edges    = 0;
  int  issue_at = 0;
  int  n_cmp    = 0;
  int  n_bad    = 0;
  wr_t wr_exp[$];
  dn_t dn_exp[$];
  wr_t w;
  dn_t d;

  // RAM with one-cycle read latency; DUT writes are observed by the monitor only.
  always @(posedge clk) begin
    edges         <= edges + 1;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [1:0] o, input int a, input int b,
                                           input int at);
    int v;
    case (o)
      2'd0:    v = a + b;
      2'd1:    v = a - b;
      2'd2:    v = a * b;
      default: v = at;
    endcase
`ifdef MATRIX_ENGINE_SAT_EN
    if (v > Top) v = Top;
    if (v < 0) v = 0;
`endif
    return DW'(v & Top);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        seen[bus.mem_addr] = bus.mem_wdata;
        if (wr_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_write: actual addr %0d data %0d required no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          w = wr_exp.pop_front();
          chk("wr_addr", bus.mem_addr, w.addr);
          chk("wr_data", bus.mem_wdata, w.data);
        end
      end
      if (bus.done) begin
        if (dn_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_done: actual done=1 at edge %0d required no done", edges);
        end else begin
          d = dn_exp.pop_front();
          chk("done_cycle", edges, d.at);
          chk("done_error", bus.error, d.err);
          chk("done_busy", bus.busy, 0);
        end
      end
    end
  end

  task automatic setup(input logic [AW-1:0] b, input int nw);
    ram[b] = DW'(nw);
    if (nw >= 1 && nw <= MAXN) begin
      for (int i = 1; i <= 2 * nw * nw; i++) ram[b + AW'(i)] = DW'($urandom);
    end
  endtask

  // Must be called on a negedge; predicts writes and done timing from the RAM image.
  task automatic issue(input logic [1:0] o, input logic [AW-1:0] b);
    int n;
    int ma [MAXN][MAXN];
    int mb [MAXN][MAXN];
    logic [AW-1:0] p;
    n = int'(ram[b]);
    if (n == 0 || n > MAXN) begin
      dn_exp.push_back('{at: edges + 3, err: 1'b1});
    end else begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          p = b + AW'(1 + r * n + c);
          ma[r][c] = int'(ram[p]);
          p = b + AW'(1 + n * n + r * n + c);
          mb[r][c] = int'(ram[p]);
        end
      end
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          p = b + AW'(1 + 2 * n * n + r * n + c);
          wr_exp.push_back('{addr: p, data: ref_op(o, ma[r][c], mb[r][c], ma[c][r])});
        end
      end
      dn_exp.push_back('{at: edges + 3 * n * n + 3, err: 1'b0});
    end
    issue_at  = edges;
    bus.op    = o;
    bus.base  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic recover();
    rst_n = 1'b0;
    wr_exp.delete();
    dn_exp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(output int lat);
    int i;
    i = 0;
    while (bus.done !== 1'b1 && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (bus.done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: actual no done after %0d cycles required done", i);
      lat = -1;
      recover();
    end else begin
      lat = edges - issue_at;
    end
  endtask

  initial begin
    int lat;
    int i;
    int nw;
    logic [AW-1:0] b;
    logic [1:0] o;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.base  = '0;
    for (int j = 0; j < 256; j++) ram[j] = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    setup(0, 2);
    for (int j = 0; j < 4; j++) begin
      ram[1 + j] = DW'(j + 1);
      ram[5 + j] = DW'(10 * (j + 1));
    end
    issue(2'd0, 8'd0);
    wait_done(lat);
    chk("add_latency", lat, 15);
    chk("add_error", bus.error, 0);
    chk("add_r0", seen[9], 11);
    chk("add_r1", seen[10], 22);
    chk("add_r2", seen[11], 33);
    chk("add_r3", seen[12], 44);

    setup(40, 1);
    ram[41] = 8'd3;
    ram[42] = 8'd5;
    issue(2'd1, 8'd40);
    wait_done(lat);
    chk("sub_latency", lat, 6);
`ifdef MATRIX_ENGINE_SAT_EN
    chk("sub_r", seen[43], 0);
`else
    chk("sub_r", seen[43], 254);
`endif

    setup(50, 1);
    ram[51] = 8'd20;
    ram[52] = 8'd20;
    issue(2'd2, 8'd50);
    wait_done(lat);
`ifdef MATRIX_ENGINE_SAT_EN
    chk("mul_r", seen[53], 255);
`else
    chk("mul_r", seen[53], 144);
`endif

    setup(100, 3);
    for (int j = 0; j < 9; j++) ram[101 + j] = DW'(j + 1);
    issue(2'd3, 8'd100);
    wait_done(lat);
    chk("tr_latency", lat, 30);
    chk("tr_r0", seen[119], 1);
    chk("tr_r1", seen[120], 4);
    chk("tr_r2", seen[121], 7);
    chk("tr_r3", seen[122], 2);
    chk("tr_r8", seen[127], 9);

    setup(200, 0);
    issue(2'd0, 8'd200);
    wait_done(lat);
    chk("size0_latency", lat, 3);
    chk("size0_error", bus.error, 1);
    setup(210, 6);
    issue(2'd2, 8'd210);
    wait_done(lat);
    chk("size6_latency", lat, 3);
    repeat (3) @(negedge clk);
    chk("error_held", bus.error, 1);

    // A start pulse during LOAD must not re-latch op or base.
    setup(60, 2);
    issue(2'd0, 8'd60);
    chk("error_cleared", bus.error, 0);
    repeat (3) @(negedge clk);
    chk("busy_in_load", bus.busy, 1);
    bus.op    = 2'd3;
    bus.base  = 8'd150;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("busy_start_latency", lat, 15);

    // Asynchronous reset in the middle of EXEC.
    setup(130, 3);
    issue(2'd2, 8'd130);
    i = 0;
    while (bus.mem_we !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("exec_reached", bus.mem_we, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exec_we", bus.mem_we, 0);
    chk("rst_exec_busy", bus.busy, 0);
    chk("rst_exec_done", bus.done, 0);
    wr_exp.delete();
    dn_exp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    setup(130, 3);
    issue(2'd0, 8'd130);
    wait_done(lat);
    chk("after_rst_latency", lat, 30);

    for (int j = 0; j < 24; j++) begin
      if ($urandom_range(0, 5) == 0) begin
        nw = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(6, 255));
      end else begin
        nw = int'($urandom_range(1, MAXN));
      end
      b = AW'($urandom);
      o = 2'($urandom_range(0, 3));
      setup(b, nw);
      issue(o, b);
      wait_done(lat);
      chk("rand_latency", lat, (nw >= 1 && nw <= MAXN) ? 3 * nw * nw + 3 : 3);
    end

    repeat (3) @(negedge clk);
    chk("left_writes", wr_exp.size(), 0);
    chk("left_done", dn_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
